flight_physics_param: RTL and testbench

//  Parametrised next-generation bird flight engine. Integrates gravity and flap impulse on a divided

---
 rtl/flight_physics_param.sv | 109 ++++++++++
 tb/tb_flight_physics_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/flight_physics_param.sv
// flight_physics_param: bird flight engine with divided physics tick, ceiling/floor clamp and INIT/FLY/DEAD FSM
// Ports: Clk/reset_n clock and async active-low reset; Start, Ack, BtnPress, Collide level inputs;
//   VertSpeed signed speed (+ve falling), Bird_X/Bird_Y pixel position, Tick physics pulse,
//   Dead high in DEAD, State 00 INIT / 01 FLY / 10 DEAD.
module flight_physics_param #(
  parameter int W        = 10,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int MAX_FALL = 12,
  parameter int TICK_DIV = 4,
  parameter int BIRD_X   = 160,
  parameter int START_Y  = 240,
  parameter int CEIL_Y   = 0,
  parameter int FLOOR_Y  = 440
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic         Start,
  input  logic         Ack,
  input  logic         BtnPress,
  input  logic         Collide,
  output logic [W-1:0] VertSpeed,
  output logic [W-1:0] Bird_X,
  output logic [W-1:0] Bird_Y,
  output logic         Tick,
  output logic         Dead,
  output logic [1:0]   State
);
  localparam int CW = $clog2(TICK_DIV) + 1;
  localparam logic signed [W+1:0] G_S     = (W+2)'(GRAVITY);
  localparam logic signed [W+1:0] FLAP_S  = -((W+2)'(FLAP_VEL));
  localparam logic signed [W+1:0] MAXF_S  = (W+2)'(MAX_FALL);
  localparam logic signed [W+1:0] CEIL_S  = (W+2)'(CEIL_Y);
  localparam logic signed [W+1:0] FLOOR_S = (W+2)'(FLOOR_Y);
  typedef enum logic [1:0] {INIT = 2'b00, FLY = 2'b01, DEAD = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] y_q, y_d, v_q, v_d;
  logic pend_q, pend_d, btn_q, flap_edge, tick;
  logic signed [W+1:0] v_fall, v1, y1;
  assign flap_edge = BtnPress & ~btn_q;
  assign tick      = (state_q == FLY) && (cnt_q == CW'(TICK_DIV - 1));
  // Widened by two bits so the position sum cannot wrap before the clamps are applied.
  assign v_fall    = $signed({{2{v_q[W-1]}}, v_q}) + G_S;
  assign v1        = (pend_q | flap_edge) ? FLAP_S : (v_fall > MAXF_S ? MAXF_S : v_fall);
  assign y1        = $signed({2'b00, y_q}) + v1;
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    pend_d  = 1'b0;
    cnt_d   = '0;
    case (state_q)
      INIT: begin
        y_d     = W'(START_Y);
        v_d     = '0;
        state_d = Start ? FLY : INIT;
      end
      FLY: begin
        if (Collide) state_d = DEAD;
        else if (tick) begin
          if (y1 <= CEIL_S) begin
            y_d = W'(CEIL_Y);
            v_d = '0;
          end else if (y1 >= FLOOR_S) begin
            y_d     = W'(FLOOR_Y);
            v_d     = '0;
            state_d = DEAD;
          end else begin
            y_d = y1[W-1:0];
            v_d = v1[W-1:0];
          end
        end else begin
          pend_d = pend_q | flap_edge;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DEAD: begin
        state_d = Ack ? INIT : DEAD;
        y_d     = Ack ? W'(START_Y) : y_q;
        v_d     = Ack ? '0 : v_q;
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      y_q     <= W'(START_Y);
      v_q     <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      btn_q   <= BtnPress;
    end
  end
  assign VertSpeed = v_q;
  assign Bird_X    = W'(BIRD_X);
  assign Bird_Y    = y_q;
  assign Tick      = tick;
  assign Dead      = state_q == DEAD;
  assign State     = state_q;
endmodule

// File: tb/tb_flight_physics_param.sv
// tb_flight_physics_param: directed stimulus with a per-cycle integer reference model and literal pins
module tb_flight_physics_param;
  localparam int TD = 4;
  logic Clk = 1'b0, reset_n = 1'b0, Start = 1'b0, Ack = 1'b0, BtnPress = 1'b0, Collide = 1'b0;
  logic [9:0] VertSpeed, Bird_X, Bird_Y;
  logic Tick, Dead;
  logic [1:0] State;
  int checks = 0, failures = 0;
  int ms, my, mv, mc, mp, mb;
  flight_physics_param #(.W(10), .GRAVITY(1), .FLAP_VEL(8), .MAX_FALL(12), .TICK_DIV(TD),
    .BIRD_X(160), .START_Y(240), .CEIL_Y(0), .FLOOR_Y(440)) dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Ack(Ack), .BtnPress(BtnPress), .Collide(Collide),
    .VertSpeed(VertSpeed), .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Tick(Tick), .Dead(Dead), .State(State));
  always #5 Clk = ~Clk;
  always @(posedge Clk or negedge reset_n) begin
    int e, nv, ny;
    if (!reset_n) begin
      ms = 0; my = 240; mv = 0; mc = 0; mp = 0; mb = 0;
    end else begin
      e = (BtnPress && !mb) ? 1 : 0;
      mb = BtnPress ? 1 : 0;
      if (ms == 0) begin
        my = 240; mv = 0; mp = 0; mc = 0;
        if (Start) ms = 1;
      end else if (ms == 1) begin
        if (Collide) begin
          ms = 2; mp = 0; mc = 0;
        end else if (mc == TD - 1) begin
          nv = (mp || e) ? -8 : ((mv + 1 > 12) ? 12 : mv + 1);
          ny = my + nv;
          if (ny <= 0) begin my = 0; mv = 0; end
          else if (ny >= 440) begin my = 440; mv = 0; ms = 2; end
          else begin my = ny; mv = nv; end
          mp = 0; mc = 0;
        end else begin
          mp = (mp || e) ? 1 : 0;
          mc = mc + 1;
        end
      end else if (Ack) begin
        ms = 0; my = 240; mv = 0;
      end
    end
  end
  always @(negedge Clk) begin
    int mt;
    mt = (ms == 1 && mc == TD - 1) ? 1 : 0;
    checks++;
    if (State !== 2'(ms) || Bird_Y !== 10'(my) || $signed(VertSpeed) !== 10'(mv) || Tick !== mt[0] ||
        Dead !== (ms == 2) || Bird_X !== 10'd160) begin
      failures++;
      $display("FAIL cycle_model t=%0t got st=%0d y=%0d v=%0d tick=%0b dead=%0b x=%0d want st=%0d y=%0d v=%0d tick=%0d dead=%0d x=160",
        $time, State, Bird_Y, $signed(VertSpeed), Tick, Dead, Bird_X, ms, my, mv, mt, ms == 2);
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask
  task automatic wait_tick();
    int n = 0;
    while (!Tick && n < 40) begin
      cyc(1);
      n++;
    end
    if (!Tick) begin
      failures++;
      $display("FAIL wait_tick got=no_tick want=tick");
    end
    cyc(1);
  endtask
  initial begin
    int n, yb;
    repeat (5) @(posedge Clk);
    #2 reset_n = 1'b1;
    cyc(1);
    chk("t1_state", State, 0);
    chk("t1_y", Bird_Y, 240);
    chk("t1_v", $signed(VertSpeed), 0);
    chk("t1_x", Bird_X, 160);
    chk("t1_dead", Dead, 0);
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      chk("t2_v", $signed(VertSpeed), k);
      chk("t2_y", Bird_Y, 240 + k * (k + 1) / 2);
    end
    n = 0;
    while (!Dead && n < 200) begin
      cyc(1);
      n++;
    end
    chk("t2_floor_y", Bird_Y, 440);
    chk("t2_floor_state", State, 2);
    chk("t2_floor_dead", Dead, 1);
    Ack = 1'b1;
    cyc(1);
    Ack = 1'b0;
    chk("t2_ack_state", State, 0);
    chk("t2_ack_y", Bird_Y, 240);
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    repeat (5) wait_tick();
    chk("t3_pre_v", $signed(VertSpeed), 5);
    chk("t3_pre_y", Bird_Y, 255);
    BtnPress = 1'b1;
    wait_tick();
    chk("t3_flap_v", $signed(VertSpeed), -8);
    chk("t3_flap_y", Bird_Y, 247);
    wait_tick();
    chk("t3_next_v", $signed(VertSpeed), -7);
    chk("t3_next_y", Bird_Y, 240);
    cyc(12);
    BtnPress = 1'b0;
    chk("t3_hold_v", $signed(VertSpeed), -4);
    chk("t3_hold_y", Bird_Y, 225);
    n = 0;
    while (Bird_Y != 0 && n < 60) begin
      BtnPress = 1'b1;
      cyc(1);
      BtnPress = 1'b0;
      wait_tick();
      n++;
    end
    chk("t4_ceil_y", Bird_Y, 0);
    chk("t4_ceil_v", $signed(VertSpeed), 0);
    chk("t4_ceil_state", State, 1);
    n = 0;
    while (!Tick && n < 10) begin
      cyc(1);
      n++;
    end
    Collide = 1'b1;
    yb = Bird_Y;
    cyc(1);
    Collide = 1'b0;
    chk("t5_collide_state", State, 2);
    chk("t5_collide_y", Bird_Y, yb);
    chk("t5_collide_dead", Dead, 1);
    Start = 1'b1;
    Ack = 1'b1;
    cyc(1);
    Ack = 1'b0;
    chk("t5_ack_wins_state", State, 0);
    chk("t5_ack_y", Bird_Y, 240);
    chk("t5_ack_v", $signed(VertSpeed), 0);
    cyc(1);
    Start = 1'b0;
    chk("t5_start_state", State, 1);
    n = 0;
    while (!Tick && n < 10) begin
      cyc(1);
      n++;
    end
    chk("t5_first_tick_delay", n + 1, 4);
    cyc(1);
    BtnPress = 1'b1;
    wait_tick();
    chk("t6_pre_v", $signed(VertSpeed), -8);
    BtnPress = 1'b0;
    cyc(1);
    BtnPress = 1'b1;
    cyc(1);
    BtnPress = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_state", State, 0);
    chk("t6_async_y", Bird_Y, 240);
    chk("t6_async_v", $signed(VertSpeed), 0);
    chk("t6_async_tick", Tick, 0);
    chk("t6_async_dead", Dead, 0);
    repeat (2) @(posedge Clk);
    #2 reset_n = 1'b1;
    Start = 1'b1;
    cyc(1);
    Start = 1'b0;
    wait_tick();
    chk("t6_restart_v", $signed(VertSpeed), 1);
    chk("t6_restart_y", Bird_Y, 241);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
